// File: rtl/xor_bramka_core.sv
// Bitwise XOR gate with a zero-latency combinational result and a small
// registered observation stage: registered result, parity of the result, and a
// saturating count of enabled cycles in which the operands differed.
module xor_bramka_core #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] c_q,
  output logic             par_q,
  output logic [CNT_W-1:0] diff_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [WIDTH-1:0] cap_q, cap_d;
  logic             par_reg_q, par_reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Gate itself: no clock or reset on this path, X on an input propagates.
  assign c = a ^ b;

  // Next-state for capture, parity and the saturating difference counter.
  always_comb begin
    cap_d     = cap_q;
    par_reg_d = par_reg_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;

    if (en) begin
      cap_d     = c;
      par_reg_d = ^c;
    end

    // Clear wins over an increment landing on the same edge.
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (en && (|c) && !sat_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CntMax) begin
        sat_d = 1'b1;
      end
    end
  end

  // Observation registers; reset is asynchronous and held while asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q     <= '0;
      par_reg_q <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      par_reg_q <= par_reg_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign c_q      = cap_q;
  assign par_q    = par_reg_q;
  assign diff_cnt = cnt_q;
  assign cnt_sat  = sat_q;

endmodule

// File: tb/tb_xor_bramka_core.sv
// Directed bench for xor_bramka_core: a 1-bit instance for the clockless gate
// check and a 4-bit instance with a 3-bit counter for the registered stage.
`timescale 1ns/1ps
module tb_xor_bramka_core;

  logic clk;
  logic clk_run;
  logic rst;
  logic en;
  logic clr;

  // 1-bit instance
  logic       a1, b1, c1, cq1, par1, sat1;
  logic [15:0] cnt1;

  // 4-bit instance, 3-bit counter
  logic [3:0] a4, b4, c4, cq4;
  logic       par4, sat4;
  logic [2:0] cnt4;

  int n_checks;
  int n_pass;

  xor_bramka_core #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .a       (a1),
    .b       (b1),
    .c       (c1),
    .en      (en),
    .clr     (clr),
    .c_q     (cq1),
    .par_q   (par1),
    .diff_cnt(cnt1),
    .cnt_sat (sat1)
  );

  xor_bramka_core #(.WIDTH(4), .CNT_W(3)) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .a       (a4),
    .b       (b4),
    .c       (c4),
    .en      (en),
    .clr     (clr),
    .c_q     (cq4),
    .par_q   (par4),
    .diff_cnt(cnt4),
    .cnt_sat (sat4)
  );

  // Gated clock so the first phase can run with clk static.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_in  [4];
  logic       tt_exp [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clk      = 1'b0;
    clk_run  = 1'b0;
    rst      = 1'b0;
    en       = 1'b0;
    clr      = 1'b0;
    a1 = 1'b0; b1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0;

    // Clockless truth table on the 1-bit gate.
    tt_in[0] = 2'b00; tt_exp[0] = 1'b0;
    tt_in[1] = 2'b01; tt_exp[1] = 1'b1;
    tt_in[2] = 2'b10; tt_exp[2] = 1'b1;
    tt_in[3] = 2'b11; tt_exp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1 = tt_in[i][1];
      b1 = tt_in[i][0];
      #1;
      check($sformatf("truth_%0d", i), {31'b0, c1}, {31'b0, tt_exp[i]});
    end
    a1 = 1'b1; b1 = 1'b1;
    #49;
    check("hold_11", {31'b0, c1}, 32'h0);
    a1 = 1'b0; b1 = 1'b0;
    #1;
    check("back_00", {31'b0, c1}, 32'h0);
    a1 = 1'bx; b1 = 1'b0;
    #1;
    check("x_prop", {31'b0, c1}, {31'b0, 1'bx});
    a1 = 1'b0;

    // Reset held: gate still works, registers pinned to zero.
    rst = 1'b1;
    #1;
    check("rst_cq", {28'b0, cq4}, 32'h0);
    check("rst_cnt", {29'b0, cnt4}, 32'h0);
    a4 = 4'hC; b4 = 4'h5;
    #1;
    check("rst_c_C5", {28'b0, c4}, 32'h9);
    en = 1'b1;
    clk_run = 1'b1;
    tick();
    tick();
    check("rst_hold_cq", {28'b0, cq4}, 32'h0);
    check("rst_hold_par", {31'b0, par4}, 32'h0);
    check("rst_hold_cnt", {29'b0, cnt4}, 32'h0);
    check("rst_hold_sat", {31'b0, sat4}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // First capture.
    a4 = 4'hA; b4 = 4'h3;
    #1;
    check("c_A3", {28'b0, c4}, 32'h9);
    tick();
    check("cq_A3", {28'b0, cq4}, 32'h9);
    check("par_A3", {31'b0, par4}, 32'h0);
    check("cnt_A3", {29'b0, cnt4}, 32'h1);
    a4 = 4'h5; b4 = 4'h5;
    #1;
    check("c_55", {28'b0, c4}, 32'h0);
    tick();
    check("cnt_55", {29'b0, cnt4}, 32'h1);
    check("cq_55", {28'b0, cq4}, 32'h0);
    a4 = 4'h1; b4 = 4'h0;
    tick();
    check("par_odd", {31'b0, par4}, 32'h1);
    check("cnt_odd", {29'b0, cnt4}, 32'h2);

    // Clear beats an increment; capture still happens.
    a4 = 4'hF; b4 = 4'h0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_cnt", {29'b0, cnt4}, 32'h0);
    check("clr_sat", {31'b0, sat4}, 32'h0);
    check("clr_cq", {28'b0, cq4}, 32'hF);
    check("clr_par", {31'b0, par4}, 32'h0);

    // Saturation with a 3-bit counter over nine differing cycles.
    a4 = 4'h6; b4 = 4'h0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("sat_cnt_%0d", k), {29'b0, cnt4}, (k >= 7) ? 32'd7 : k);
      check($sformatf("sat_flag_%0d", k), {31'b0, sat4}, (k >= 7) ? 32'd1 : 32'd0);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("unsat_cnt", {29'b0, cnt4}, 32'h0);
    check("unsat_sat", {31'b0, sat4}, 32'h0);

    // Count to five, then hold with en low.
    a4 = 4'h8; b4 = 4'h0;
    for (int k = 0; k < 5; k++) tick();
    check("cnt_five", {29'b0, cnt4}, 32'h5);
    check("cq_8", {28'b0, cq4}, 32'h8);
    en = 1'b0;
    a4 = 4'h3; b4 = 4'h5;
    #1;
    check("en0_c", {28'b0, c4}, 32'h6);
    tick();
    tick();
    check("en0_cnt", {29'b0, cnt4}, 32'h5);
    check("en0_cq", {28'b0, cq4}, 32'h8);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check("async_cnt", {29'b0, cnt4}, 32'h0);
    check("async_cq", {28'b0, cq4}, 32'h0);
    check("async_c", {28'b0, c4}, 32'h6);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
